pipelined_alu_regmem: RTL and testbench

Parametrised, single-clock successor to the two-phase pipelined ALU with memory store. Executes one register-to-register ALU operation per cycle through a 4-stage pipeline: operand read, execute, register write-back, memory store. Provides in/out valid qualification and optional operand forwarding. Sits between the instruction sequencer and the data memory of the datapath.

---
 rtl/pipelined_alu_regmem.sv | 138 +++++++++++++
 tb/tb_pipelined_alu_regmem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_regmem.sv
// Four-stage single-clock ALU pipeline: operand read, execute, register write-back, memory store.
// Define FORWARDING_EN to bypass in-flight ALU results to the operand-read stage.
module pipelined_alu_regmem #(
    parameter int WIDTH     = 16,
    parameter int NREG      = 16,
    parameter int MEM_DEPTH = 256,
    localparam int RW       = $clog2(NREG),
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [RW-1:0]    s1,
    input  logic [RW-1:0]    s2,
    input  logic [RW-1:0]    r_addr,
    input  logic [3:0]       opr,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] Zout,
    output logic             out_valid,
    output logic             zero
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PASSA,
        OP_SHL, OP_SHR, OP_NEG, OP_SLTU, OP_INC, OP_DEC, OP_PASSB, OP_ZERO
    } op_e;

    logic [WIDTH-1:0] register_bank [0:NREG-1];
    logic [WIDTH-1:0] memory        [0:MEM_DEPTH-1];

    // Stage 1: latched operands and control
    logic [WIDTH-1:0] a1, b1;
    logic [RW-1:0]    rd1;
    op_e              op1;
    logic [AW-1:0]    addr1;
    logic             v1;

    // Stage 2: registered ALU result
    logic [WIDTH-1:0] z2;
    logic [RW-1:0]    rd2;
    logic [AW-1:0]    addr2;
    logic             v2;

    // Stage 3: result on its way to memory
    logic [WIDTH-1:0] z3;
    logic [AW-1:0]    addr3;
    logic             v3;

    logic [WIDTH-1:0] z1, a_fwd, b_fwd;

    function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input op_e              op);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_MUL:   r = a * b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOT:   r = ~a;
            OP_PASSA: r = a;
            OP_SHL:   r = a << b[3:0];
            OP_SHR:   r = a >> b[3:0];
            OP_NEG:   r = '0 - a;
            OP_SLTU:  r = (a < b) ? WIDTH'(1) : '0;
            OP_INC:   r = a + WIDTH'(1);
            OP_DEC:   r = a - WIDTH'(1);
            OP_PASSB: r = b;
            OP_ZERO:  r = '0;
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign z1 = alu(a1, b1, op1);

    // The instruction one ahead is still in stage 1, so its result is the
    // combinational ALU output; two ahead is the stage-2 register, whose bank
    // write lands on the same edge as this read and would otherwise be missed.
    always_comb begin
        a_fwd = register_bank[s1];
        b_fwd = register_bank[s2];
`ifdef FORWARDING_EN
        if (v1 && rd1 == s1)      a_fwd = z1;
        else if (v2 && rd2 == s1) a_fwd = z2;
        if (v1 && rd1 == s2)      b_fwd = z1;
        else if (v2 && rd2 == s2) b_fwd = z2;
`endif
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            rd1       <= '0;
            op1       <= OP_ADD;
            addr1     <= '0;
            v2        <= 1'b0;
            z2        <= '0;
            rd2       <= '0;
            addr2     <= '0;
            v3        <= 1'b0;
            z3        <= '0;
            addr3     <= '0;
            Zout      <= '0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            a1        <= a_fwd;
            b1        <= b_fwd;
            rd1       <= r_addr;
            op1       <= op_e'(opr);
            addr1     <= addr;
            v2        <= v1;
            z2        <= z1;
            rd2       <= rd1;
            addr2     <= addr1;
            v3        <= v2;
            z3        <= z2;
            addr3     <= addr2;
            out_valid <= v3;
            if (v3) Zout <= z3;
        end
    end

    // Storage is never cleared; reset only kills the valid bits feeding these writes.
    always_ff @(posedge clk_1) begin
        if (v2) register_bank[rd2] <= z2;
        if (v3) memory[addr3]      <= z3;
    end

    assign zero = out_valid && (Zout == '0);

endmodule

// File: tb/tb_pipelined_alu_regmem.sv
// Scoreboard bench for pipelined_alu_regmem: directed vectors, expected results queued at issue.
// Expectations for the dependent SUB follow FORWARDING_EN.
module tb_pipelined_alu_regmem;

    localparam int WIDTH     = 16;
    localparam int NREG      = 16;
    localparam int MEM_DEPTH = 256;

`ifdef FORWARDING_EN
    localparam logic [15:0] EXP_B = 16'd6;
`else
    localparam logic [15:0] EXP_B = 16'd8;
`endif

    logic        clk_1 = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  s1, s2, r_addr, opr;
    logic [7:0]  addr;
    logic [15:0] Zout;
    logic        out_valid, zero;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int          run_len = 0;
    int          last_run = 0;
    logic [15:0] f_exp [0:5];

    always #5 clk_1 = ~clk_1;

    pipelined_alu_regmem #(
        .WIDTH(WIDTH),
        .NREG(NREG),
        .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk_1(clk_1),
        .rst(rst),
        .in_valid(in_valid),
        .s1(s1),
        .s2(s2),
        .r_addr(r_addr),
        .opr(opr),
        .addr(addr),
        .Zout(Zout),
        .out_valid(out_valid),
        .zero(zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] rd, input logic [7:0] ad,
                         input logic [15:0] exp, input bit push);
        @(negedge clk_1);
        in_valid = 1'b1;
        opr      = op;
        s1       = a;
        s2       = b;
        r_addr   = rd;
        addr     = ad;
        if (push) exp_q.push_back(exp);
    endtask

    // Bubbles aim at a sentinel register/address so any stray write is visible.
    task automatic idle();
        @(negedge clk_1);
        in_valid = 1'b0;
        opr      = 4'd0;
        s1       = 4'd0;
        s2       = 4'd0;
        r_addr   = 4'd9;
        addr     = 8'd200;
    endtask

    always @(negedge clk_1) begin
        if (rst) begin
            run_len = 0;
        end else if (out_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got Zout %h with no result pending", Zout);
            end else begin
                mon_e = exp_q.pop_front();
                check("zout", 32'(Zout), 32'(mon_e));
                check("zero", 32'(zero), 32'(mon_e == 16'd0));
            end
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        s1 = 4'd0; s2 = 4'd0; r_addr = 4'd9; opr = 4'd0; addr = 8'd200;
        for (int i = 0; i < NREG; i++) dut.register_bank[i] = 16'(i);
        for (int i = 0; i < MEM_DEPTH; i++) dut.memory[i] = 16'd0;
        dut.memory[200] = 16'hdead;

        repeat (2) @(negedge clk_1);
        check("rst_zout", 32'(Zout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;

        // Single ADD and its latency
        issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd125, 16'd8, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("lat_ov_low", 32'(out_valid), 32'd0);
        end
        idle();
        check("lat_ov_high", 32'(out_valid), 32'd1);
        repeat (2) idle();
        check("bank10", 32'(dut.register_bank[10]), 32'd8);
        check("mem125", 32'(dut.memory[125]), 32'd8);

        // Back-to-back dependency
        dut.register_bank[10] = 16'd10;
        issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd127, 16'd8, 1'b1);
        issue(4'd1, 4'd10, 4'd2, 4'd12, 8'd126, EXP_B, 1'b1);
        repeat (5) idle();
        check("mem126_dep", 32'(dut.memory[126]), 32'(EXP_B));
        check("bank12_dep", 32'(dut.register_bank[12]), 32'(EXP_B));
        check("mem127", 32'(dut.memory[127]), 32'd8);

        // MUL truncation, SLTU false, SHL by 15
        dut.register_bank[4] = 16'h0100;
        issue(4'd2, 4'd4, 4'd4, 4'd13, 8'd128, 16'h0000, 1'b1);
        issue(4'd11, 4'd7, 4'd3, 4'd14, 8'd129, 16'h0000, 1'b1);
        issue(4'd8, 4'd1, 4'd15, 4'd15, 8'd130, 16'h8000, 1'b1);
        repeat (5) idle();
        check("bank15_shl", 32'(dut.register_bank[15]), 32'h8000);

        // One bubble between two instructions
        issue(4'd4, 4'd6, 4'd9, 4'd11, 8'd140, 16'd15, 1'b1);
        idle();
        issue(4'd5, 4'd7, 4'd5, 4'd0, 8'd141, 16'd2, 1'b1);
        idle();
        idle();
        check("bubble_ov_first", 32'(out_valid), 32'd1);
        idle();
        check("bubble_ov_gap", 32'(out_valid), 32'd0);
        idle();
        check("bubble_ov_second", 32'(out_valid), 32'd1);
        repeat (3) idle();
        check("bubble_mem200", 32'(dut.memory[200]), 32'hdead);
        check("bubble_bank9", 32'(dut.register_bank[9]), 32'd9);
        check("mem140", 32'(dut.memory[140]), 32'd15);
        check("mem141", 32'(dut.memory[141]), 32'd2);

        // Reset with three instructions in flight
        issue(4'd0, 4'd6, 4'd7, 4'd8, 8'd150, 16'd13, 1'b0);
        issue(4'd1, 4'd9, 4'd1, 4'd1, 8'd151, 16'd8, 1'b0);
        issue(4'd12, 4'd6, 4'd0, 4'd2, 8'd152, 16'd7, 1'b0);
        @(negedge clk_1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_zout", 32'(Zout), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk_1);
        rst = 1'b0;
        repeat (6) idle();
        check("rst_bank8_kept", 32'(dut.register_bank[8]), 32'd13);
        check("rst_mem150", 32'(dut.memory[150]), 32'd0);
        check("rst_mem151", 32'(dut.memory[151]), 32'd0);
        check("rst_mem152", 32'(dut.memory[152]), 32'd0);
        check("rst_bank1", 32'(dut.register_bank[1]), 32'd1);
        check("rst_bank2", 32'(dut.register_bank[2]), 32'd2);

        // Six consecutive stores
        f_exp[0] = 16'hfffc; f_exp[1] = 16'hfffe; f_exp[2] = 16'hfffb;
        f_exp[3] = 16'h0005; f_exp[4] = 16'h0009; f_exp[5] = 16'h003f;
        issue(4'd6,  4'd3, 4'd0, 4'd13, 8'd125, f_exp[0], 1'b1);
        issue(4'd1,  4'd3, 4'd5, 4'd13, 8'd126, f_exp[1], 1'b1);
        issue(4'd10, 4'd5, 4'd0, 4'd13, 8'd127, f_exp[2], 1'b1);
        issue(4'd13, 4'd6, 4'd0, 4'd13, 8'd128, f_exp[3], 1'b1);
        issue(4'd14, 4'd0, 4'd9, 4'd13, 8'd129, f_exp[4], 1'b1);
        issue(4'd2,  4'd7, 4'd9, 4'd13, 8'd130, f_exp[5], 1'b1);
        repeat (6) idle();
        check("run_out_valid", 32'(last_run), 32'd6);
        for (int i = 0; i < 6; i++)
            check("burst_mem", 32'(dut.memory[125 + i]), 32'(f_exp[i]));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
